id_ex_stage: RTL and testbench

//  ID/EX pipeline register with load-use hazard detection for the 5-stage RV32 pipeline.
//  - Captures the decoded instruction each cycle: the opcode decoder's control bundle, register addresses, operands, imm and pc.
//  - Presents the captured instruction to EX one cycle later.
//  - Inserts a bubble and stalls PC/IF-ID on a load-use hazard.
//  - Supports a squash from EX (taken branch/jump) and a hold from EX/MEM backpressure.

---
 rtl/id_ex_stage_if.sv | 61 ++++++
 rtl/id_ex_stage.sv | 90 +++++++++
 tb/tb_id_ex_stage.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs, EX-side outputs and control between decode and the ID/EX register
interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [RA_W-1:0] id_rs1_addr;
    logic [RA_W-1:0] id_rs2_addr;
    logic            id_uses_rs1;
    logic            id_uses_rs2;
    logic [RA_W-1:0] id_rd_addr;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [3:0]      id_funct;
    logic            id_branch;
    logic            id_mem_read;
    logic            id_mem_to_reg;
    logic            id_mem_write;
    logic            id_alu_src;
    logic            id_reg_write;
    logic [1:0]      id_alu_op;
    logic            ex_flush;
    logic            ex_hold;
    logic            stall_id;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [RA_W-1:0] ex_rs1_addr;
    logic [RA_W-1:0] ex_rs2_addr;
    logic [RA_W-1:0] ex_rd_addr;
    logic [3:0]      ex_funct;
    logic            ex_branch;
    logic            ex_mem_read;
    logic            ex_mem_to_reg;
    logic            ex_mem_write;
    logic            ex_alu_src;
    logic            ex_reg_write;
    logic [1:0]      ex_alu_op;

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, id_rd_addr,
               id_rs1_data, id_rs2_data, id_imm, id_funct, id_branch, id_mem_read, id_mem_to_reg,
               id_mem_write, id_alu_src, id_reg_write, id_alu_op, ex_flush, ex_hold,
        input  stall_id, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr, ex_rs2_addr,
               ex_rd_addr, ex_funct, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src,
               ex_reg_write, ex_alu_op
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, id_rd_addr,
               id_rs1_data, id_rs2_data, id_imm, id_funct, id_branch, id_mem_read, id_mem_to_reg,
               id_mem_write, id_alu_src, id_reg_write, id_alu_op, ex_flush, ex_hold,
        output stall_id, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr, ex_rs2_addr,
               ex_rd_addr, ex_funct, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src,
               ex_reg_write, ex_alu_op
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, flush and hold
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_stage_if.slave     bus,
    output logic [CNT_W-1:0] lu_stall_cnt
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1_addr;
        logic [RA_W-1:0] rs2_addr;
        logic [RA_W-1:0] rd_addr;
        logic [3:0]      funct;
        logic            branch;
        logic            mem_read;
        logic            mem_to_reg;
        logic            mem_write;
        logic            alu_src;
        logic            reg_write;
        logic [1:0]      alu_op;
    } stage_t;

    stage_t id_d, ex_q;
    logic   load_use, bubble;

    assign load_use = bus.ex_valid & bus.ex_mem_read & (bus.ex_rd_addr != '0) & bus.id_valid &
                      ((bus.id_uses_rs1 & (bus.id_rs1_addr == bus.ex_rd_addr)) |
                       (bus.id_uses_rs2 & (bus.id_rs2_addr == bus.ex_rd_addr)));
    assign bus.stall_id = ~bus.ex_flush & (bus.ex_hold | load_use);
    assign bubble       = ~bus.ex_flush & ~bus.ex_hold & load_use;

    // Gather the ID instruction; an invalid slot carries no control effects
    always_comb begin
        id_d            = '0;
        id_d.valid      = bus.id_valid;
        id_d.pc         = bus.id_pc;
        id_d.rs1_data   = bus.id_rs1_data;
        id_d.rs2_data   = bus.id_rs2_data;
        id_d.imm        = bus.id_imm;
        id_d.rs1_addr   = bus.id_rs1_addr;
        id_d.rs2_addr   = bus.id_rs2_addr;
        id_d.rd_addr    = bus.id_rd_addr;
        id_d.funct      = bus.id_funct;
        id_d.branch     = bus.id_valid & bus.id_branch;
        id_d.mem_read   = bus.id_valid & bus.id_mem_read;
        id_d.mem_to_reg = bus.id_valid & bus.id_mem_to_reg;
        id_d.mem_write  = bus.id_valid & bus.id_mem_write;
        id_d.alu_src    = bus.id_valid & bus.id_alu_src;
        id_d.reg_write  = bus.id_valid & bus.id_reg_write;
        id_d.alu_op     = {2{bus.id_valid}} & bus.id_alu_op;
    end

    // Stage register: flush or bubble clears, hold freezes, otherwise advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      ex_q <= '0;
        else if (bus.ex_flush || bubble) ex_q <= '0;
        else if (!bus.ex_hold)           ex_q <= id_d;
    end

    // Saturating count of load-use bubbles actually inserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              lu_stall_cnt <= '0;
        else if (bubble && lu_stall_cnt != '1)   lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_pc         = ex_q.pc;
    assign bus.ex_rs1_data   = ex_q.rs1_data;
    assign bus.ex_rs2_data   = ex_q.rs2_data;
    assign bus.ex_imm        = ex_q.imm;
    assign bus.ex_rs1_addr   = ex_q.rs1_addr;
    assign bus.ex_rs2_addr   = ex_q.rs2_addr;
    assign bus.ex_rd_addr    = ex_q.rd_addr;
    assign bus.ex_funct      = ex_q.funct;
    assign bus.ex_branch     = ex_q.branch;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_alu_src    = ex_q.alu_src;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_alu_op     = ex_q.alu_op;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed table, hand sequences and random stimulus against a behavioural model
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cnt_main;
    logic [1:0]  cnt_small;

    id_ex_stage_if #(.XLEN(32), .RA_W(5)) bus ();
    id_ex_stage_if #(.XLEN(32), .RA_W(5)) sbus ();

    id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus),  .lu_stall_cnt(cnt_main));
    // Narrow-counter twin fed the same stimulus, so saturation is reachable in a few events
    id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(2))  sdut (.clk(clk), .rst_n(rst_n), .bus(sbus), .lu_stall_cnt(cnt_small));

    always #5 clk = ~clk;

    // Mirror the main stimulus onto the narrow-counter twin
    always_comb begin
        sbus.id_valid      = bus.id_valid;
        sbus.id_pc         = bus.id_pc;
        sbus.id_rs1_addr   = bus.id_rs1_addr;
        sbus.id_rs2_addr   = bus.id_rs2_addr;
        sbus.id_uses_rs1   = bus.id_uses_rs1;
        sbus.id_uses_rs2   = bus.id_uses_rs2;
        sbus.id_rd_addr    = bus.id_rd_addr;
        sbus.id_rs1_data   = bus.id_rs1_data;
        sbus.id_rs2_data   = bus.id_rs2_data;
        sbus.id_imm        = bus.id_imm;
        sbus.id_funct      = bus.id_funct;
        sbus.id_branch     = bus.id_branch;
        sbus.id_mem_read   = bus.id_mem_read;
        sbus.id_mem_to_reg = bus.id_mem_to_reg;
        sbus.id_mem_write  = bus.id_mem_write;
        sbus.id_alu_src    = bus.id_alu_src;
        sbus.id_reg_write  = bus.id_reg_write;
        sbus.id_alu_op     = bus.id_alu_op;
        sbus.ex_flush      = bus.ex_flush;
        sbus.ex_hold       = bus.ex_hold;
    end

    typedef struct packed {
        bit        valid;
        bit [31:0] pc, rs1d, rs2d, imm;
        bit [4:0]  rs1, rs2, rd;
        bit        u1, u2;
        bit [3:0]  funct;
        bit        br, mr, m2r, mw, as, rw;
        bit [1:0]  aluop;
        bit        flush, hold;
    } in_t;

    typedef struct packed {
        in_t       i;
        bit        stall, v, rw;
        bit [15:0] cnt;
    } tv_t;

    in_t e;
    int  cnt, cnt_s, tests, fails;
    bit  last_stall;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
        end
    endtask

    function automatic in_t mk(bit v, bit [4:0] rs1, bit [4:0] rs2, bit u1, bit u2, bit [4:0] rd,
                               bit mr, bit fl, bit hd);
        in_t i;
        i.valid = v;    i.rs1 = rs1;  i.rs2 = rs2;  i.u1 = u1;  i.u2 = u2;  i.rd = rd;
        i.pc    = $urandom; i.rs1d = $urandom; i.rs2d = $urandom; i.imm = $urandom;
        i.funct = 4'($urandom_range(0, 15));
        i.br    = 1'($urandom_range(0, 1));
        i.mw    = 1'($urandom_range(0, 1));
        i.mr    = mr;   i.m2r = mr;   i.as = mr;  i.rw = 1'b1;
        i.aluop = mr ? 2'd0 : 2'd2;
        i.flush = fl;   i.hold = hd;
        return i;
    endfunction

    function automatic bit hazard(in_t i);
        return e.valid && e.mr && e.rd != 0 && i.valid &&
               ((i.u1 && i.rs1 == e.rd) || (i.u2 && i.rs2 == e.rd));
    endfunction

    task automatic model_edge(input in_t i);
        if (i.flush) e = '0;
        else if (i.hold) e = e;
        else if (hazard(i)) begin
            e = '0;
            cnt   = (cnt == 65535) ? cnt : cnt + 1;
            cnt_s = (cnt_s == 3) ? cnt_s : cnt_s + 1;
        end else begin
            e = i;
            if (!i.valid) {e.br, e.mr, e.m2r, e.mw, e.as, e.rw, e.aluop} = '0;
        end
    endtask

    task automatic drive(input in_t i);
        bus.id_valid = i.valid;   bus.id_pc = i.pc;         bus.id_rs1_addr = i.rs1;
        bus.id_rs2_addr = i.rs2;  bus.id_uses_rs1 = i.u1;   bus.id_uses_rs2 = i.u2;
        bus.id_rd_addr = i.rd;    bus.id_rs1_data = i.rs1d; bus.id_rs2_data = i.rs2d;
        bus.id_imm = i.imm;       bus.id_funct = i.funct;   bus.id_branch = i.br;
        bus.id_mem_read = i.mr;   bus.id_mem_to_reg = i.m2r; bus.id_mem_write = i.mw;
        bus.id_alu_src = i.as;    bus.id_reg_write = i.rw;  bus.id_alu_op = i.aluop;
        bus.ex_flush = i.flush;   bus.ex_hold = i.hold;
    endtask

    task automatic check_all();
        chk("ex_valid", 64'(bus.ex_valid), 64'(e.valid));
        chk("ex_ctrl", 64'({bus.ex_branch, bus.ex_mem_read, bus.ex_mem_to_reg, bus.ex_mem_write,
                            bus.ex_alu_src, bus.ex_reg_write, bus.ex_alu_op}),
                       64'({e.br, e.mr, e.m2r, e.mw, e.as, e.rw, e.aluop}));
        chk("ex_pc", 64'(bus.ex_pc), 64'(e.pc));
        chk("ex_data", {bus.ex_rs1_data, bus.ex_rs2_data}, {e.rs1d, e.rs2d});
        chk("ex_imm", 64'(bus.ex_imm), 64'(e.imm));
        chk("ex_addr_funct", 64'({bus.ex_rs1_addr, bus.ex_rs2_addr, bus.ex_rd_addr, bus.ex_funct}),
                             64'({e.rs1, e.rs2, e.rd, e.funct}));
        chk("lu_stall_cnt", 64'(cnt_main), 64'(cnt));
        chk("lu_stall_cnt_small", 64'(cnt_small), 64'(cnt_s));
    endtask

    // One cycle: drive ID, check the combinational stall, clock, check the stage
    task automatic apply(input in_t i);
        drive(i);
        #1;
        last_stall = bus.stall_id;
        chk("stall_id", 64'(bus.stall_id), 64'(!i.flush && (i.hold || hazard(i))));
        @(posedge clk);
        model_edge(i);
        #1;
        check_all();
    endtask

    initial begin
        tv_t  tbl[15];
        in_t  add_x5, t;
        logic [31:0] held_pc;
        tests = 0; fails = 0; e = '0; cnt = 0; cnt_s = 0;
        tbl[0]  = '{mk(1, 1, 0, 1, 0, 5, 1, 0, 0), 1'b0, 1'b1, 1'b1, 16'd0};
        tbl[1]  = '{mk(1, 5, 7, 1, 1, 6, 0, 0, 0), 1'b1, 1'b0, 1'b0, 16'd1};
        tbl[2]  = '{mk(1, 5, 7, 1, 1, 6, 0, 0, 0), 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[3]  = '{mk(1, 1, 0, 1, 0, 0, 1, 0, 0), 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[4]  = '{mk(1, 0, 0, 1, 1, 6, 0, 0, 0), 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[5]  = '{mk(1, 1, 0, 1, 0, 5, 1, 0, 0), 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[6]  = '{mk(1, 1, 2, 1, 1, 6, 0, 0, 0), 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[7]  = '{mk(1, 1, 0, 1, 0, 5, 1, 0, 0), 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[8]  = '{mk(1, 1, 5, 1, 0, 6, 0, 0, 0), 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[9]  = '{mk(1, 1, 0, 1, 0, 5, 1, 0, 0), 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[10] = '{mk(1, 5, 7, 1, 1, 6, 0, 1, 0), 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[11] = '{mk(1, 5, 7, 1, 1, 6, 0, 0, 0), 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[12] = '{mk(0, 1, 2, 1, 1, 6, 1, 0, 0), 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[13] = '{mk(1, 1, 0, 1, 0, 5, 1, 0, 0), 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[14] = '{mk(0, 5, 5, 1, 1, 6, 0, 0, 0), 1'b0, 1'b0, 1'b0, 16'd1};

        drive('0);
        #12;
        check_all();
        chk("reset_stall_id", 64'(bus.stall_id), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 15; k++) begin
            apply(tbl[k].i);
            chk($sformatf("tbl%0d_stall", k), 64'(last_stall), 64'(tbl[k].stall));
            chk($sformatf("tbl%0d_valid", k), 64'(bus.ex_valid), 64'(tbl[k].v));
            chk($sformatf("tbl%0d_reg_write", k), 64'(bus.ex_reg_write), 64'(tbl[k].rw));
            chk($sformatf("tbl%0d_cnt", k), 64'(cnt_main), 64'(tbl[k].cnt));
        end

        for (int k = 0; k < 300; k++)
            apply(mk($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0));

        add_x5 = mk(1, 5, 7, 1, 1, 6, 0, 0, 0);
        apply(mk(1, 1, 2, 1, 1, 9, 0, 0, 0));
        held_pc = bus.ex_pc;
        t = mk(1, 3, 4, 1, 1, 8, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            apply(t);
            chk("hold_stall", 64'(last_stall), 64'd1);
            chk("hold_pc_stable", 64'(bus.ex_pc), 64'(held_pc));
        end
        t.hold = 1'b0;
        apply(t);
        chk("hold_release_load", 64'(bus.ex_pc), 64'(t.pc));

        apply(mk(1, 1, 0, 1, 0, 5, 1, 0, 0));
        add_x5.hold = 1'b1;
        apply(add_x5);
        apply(add_x5);
        chk("hold_lu_cnt", 64'(cnt_main), 64'(cnt));
        add_x5.hold = 1'b0;
        apply(add_x5);
        chk("after_hold_bubble", 64'({last_stall, bus.ex_valid}), 64'(2'b10));
        apply(add_x5);
        chk("after_bubble_add", 64'(bus.ex_pc), 64'(add_x5.pc));

        apply(mk(1, 1, 0, 1, 0, 5, 1, 0, 0));
        apply(mk(1, 5, 0, 1, 0, 6, 0, 1, 1));
        chk("flush_over_hold", 64'({last_stall, bus.ex_valid}), 64'd0);

        apply(mk(1, 1, 0, 1, 0, 5, 1, 0, 0));
        drive(add_x5);
        #1;
        chk("pre_reset_stall", 64'(bus.stall_id), 64'd1);
        rst_n = 1'b0;
        #1;
        e = '0; cnt = 0; cnt_s = 0;
        chk("async_reset_stall", 64'(bus.stall_id), 64'd0);
        check_all();
        #1 rst_n = 1'b1;

        for (int k = 1; k <= 5; k++) begin
            apply(mk(1, 1, 0, 1, 0, 5, 1, 0, 0));
            apply(add_x5);
            chk("sat_small_cnt", 64'(cnt_small), 64'(k < 3 ? k : 3));
            chk("sat_main_cnt", 64'(cnt_main), 64'(k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
